// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: frame sequencer for the SPI master datapath.
// Loads one frame, drops CS, enables the clock generator through TIP,
// shifts MOSI / samples MISO on the generator's strobes, then holds CS low
// for a fixed number of cycles before releasing it and pulsing done.
module spi_xfer_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int SETUP_CYCLES = 2,
  parameter int HOLD_CYCLES  = 2
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  CPHA,
  input  logic                  shift,
  input  logic                  sample,
  input  logic                  miso,
  output logic                  TIP,
  output logic                  CS,
  output logic                  mosi,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  busy,
  output logic                  done
);

  localparam int BCW      = $clog2(DATA_WIDTH + 1);
  localparam int WAIT_MAX = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int WCW      = $clog2(WAIT_MAX + 1);

  localparam logic [BCW-1:0] LAST_BIT   = BCW'(DATA_WIDTH - 1);
  localparam logic [BCW-1:0] ALL_BITS   = BCW'(DATA_WIDTH);
  localparam logic [WCW-1:0] SETUP_LAST = WCW'(SETUP_CYCLES - 1);
  localparam logic [WCW-1:0] HOLD_LAST  = WCW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD
  } state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   tx_sr;
  logic [DATA_WIDTH-1:0]   rx_sr;
  logic [BCW-1:0]          bit_cnt;
  logic [WCW-1:0]          wait_cnt;

  // Clock phase only changes edge order inside the clock generator; the
  // shift/sample rules here are identical for both modes.
  logic unused_cpha;
  assign unused_cpha = CPHA;

  // The transmit register's MSB is the line; it moves only on load, shift or reset.
  assign mosi = tx_sr[DATA_WIDTH-1];

  // Frame sequencer: state, counters, shift registers and all registered outputs.
  always_ff @(posedge sys_clk) begin
    // NOTE: every register here uses non-blocking assignment so all updates
    // see the pre-edge values, exactly like the flops they become.
    if (rst) begin
      state    <= IDLE;
      tx_sr    <= '0;
      rx_sr    <= '0;
      bit_cnt  <= '0;
      wait_cnt <= '0;
      TIP      <= 1'b0;
      CS       <= 1'b1;
      rx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            tx_sr    <= tx_data;
            rx_sr    <= '0;
            bit_cnt  <= '0;
            wait_cnt <= '0;
            CS       <= 1'b0;
            busy     <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (wait_cnt == SETUP_LAST) begin
            TIP   <= 1'b1;
            state <= XFER;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        XFER: begin
          if (bit_cnt == ALL_BITS) begin
            // Last bit was sampled on the previous edge; strobes now ignored.
            TIP      <= 1'b0;
            wait_cnt <= '0;
            state    <= HOLD;
          end else begin
            if (sample) begin
              rx_sr   <= {rx_sr[DATA_WIDTH-2:0], miso};
              bit_cnt <= bit_cnt + 1'b1;
            end
            // A shift before the first sample is the CPHA=1 leading edge (MSB
            // already on the line); a shift alongside the final sample is dropped.
            if (shift && (bit_cnt != '0) && !(sample && (bit_cnt == LAST_BIT))) begin
              tx_sr <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end
        HOLD: begin
          if (wait_cnt == HOLD_LAST) begin
            CS      <= 1'b1;
            done    <= 1'b1;
            rx_data <= rx_sr;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Self-checking bench for spi_xfer_ctrl: a clock-generator model drives the
// strobes, a frame-timeline reference predicts every output each cycle, and
// directed frames pin the reference with hand-computed values.
module tb_spi_xfer_ctrl;

  localparam int DW = 8;
  localparam int SC = 3;
  localparam int HC = 4;

  typedef logic [DW-1:0] word_t;

  logic  sys_clk = 1'b0;
  logic  rst, start, CPHA, shift, sample, miso;
  word_t tx_data;
  logic  TIP, CS, mosi, busy, done;
  word_t rx_data;

  spi_xfer_ctrl #(
    .DATA_WIDTH  (DW),
    .SETUP_CYCLES(SC),
    .HOLD_CYCLES (HC)
  ) dut (
    .sys_clk(sys_clk),
    .rst    (rst),
    .start  (start),
    .tx_data(tx_data),
    .CPHA   (CPHA),
    .shift  (shift),
    .sample (sample),
    .miso   (miso),
    .TIP    (TIP),
    .CS     (CS),
    .mosi   (mosi),
    .rx_data(rx_data),
    .busy   (busy),
    .done   (done)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- clock generator model (drives strobes on negedge) -----
  int    gen_div   = 1;
  int    gen_cnt   = 0;
  bit    gen_lead  = 1'b1;
  int    miso_mode = 0;   // 0: loopback of mosi, 1: tied high, 2: random
  bit    noise_en  = 1'b0;
  int    gen_samples = 0;
  int    gen_shifts  = 0;
  word_t mosi_word = '0;

  initial begin
    shift  = 1'b0;
    sample = 1'b0;
    miso   = 1'b0;
  end

  always @(negedge sys_clk) begin
    shift  = 1'b0;
    sample = 1'b0;
    if (TIP === 1'b1) begin
      if (gen_cnt == 0) begin
        // CPHA=0: leading edge samples, trailing shifts; CPHA=1 is the reverse.
        if (gen_lead ^ CPHA) sample = 1'b1;
        else                 shift  = 1'b1;
        gen_lead = !gen_lead;
        gen_cnt  = gen_div;
      end else begin
        gen_cnt--;
      end
    end else begin
      gen_lead = 1'b1;
      gen_cnt  = gen_div;
      if (noise_en) begin
        sample = ($urandom_range(0, 5) == 0);
        shift  = ($urandom_range(0, 5) == 0);
      end
    end
    if (TIP === 1'b1 && sample) begin
      gen_samples++;
      mosi_word = {mosi_word[DW-2:0], mosi};
    end
    if (TIP === 1'b1 && shift) gen_shifts++;
    case (miso_mode)
      0:       miso = mosi;
      1:       miso = 1'b1;
      default: miso = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- frame-timeline reference + per-cycle compare ----------
  int    n = 0;          // posedge index
  bit    m_active = 1'b0;
  int    m_t0 = 0;       // edge that accepted start
  int    m_s = -1;       // edge of the final sample, -1 until it happens
  int    m_nsamp = 0;
  word_t m_tx = '0, m_rx = '0, m_rx_data = '0;
  bit    m_done;
  bit    m_in_xfer;
  bit    exp_tip;

  // Monitor of the DUT's own edges for gap measurements.
  int    done_cnt = 0;
  int    cs_fall = 0, cs_rise = 0, tip_rise = 0, tip_fall = 0, last_gap = -1;
  logic  prev_cs = 1'b1, prev_tip = 1'b0;

  always @(posedge sys_clk) begin
    n++;
    m_done = 1'b0;
    if (rst) begin
      m_active  = 1'b0;
      m_tx      = '0;
      m_rx_data = '0;
      m_s       = -1;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1;
        m_t0     = n;
        m_s      = -1;
        m_tx     = tx_data;
        m_rx     = '0;
        m_nsamp  = 0;
      end
    end else begin
      // Strobes count only if TIP was high over the preceding cycle and the
      // final bit has not yet been taken.
      m_in_xfer = (n - 1 >= m_t0 + SC) && (m_s < 0);
      if (m_in_xfer) begin
        if (shift && m_nsamp != 0 && !(sample && m_nsamp == DW - 1)) m_tx = m_tx << 1;
        if (sample) begin
          m_rx = {m_rx[DW-2:0], miso};
          m_nsamp++;
          if (m_nsamp == DW) m_s = n;
        end
      end
      if (m_s >= 0 && n == m_s + 1 + HC) begin
        m_active  = 1'b0;
        m_done    = 1'b1;
        m_rx_data = m_rx;
      end
    end
    exp_tip = m_active && (n >= m_t0 + SC) && (m_s < 0 || n < m_s + 1);

    #1;
    check("cs",      CS,      !m_active);
    check("tip",     TIP,     exp_tip);
    check("busy",    busy,    m_active);
    check("done",    done,    m_done);
    check("mosi",    mosi,    m_tx[DW-1]);
    check("rx_data", rx_data, m_rx_data);

    if (done === 1'b1) done_cnt++;
    if (prev_cs === 1'b1 && CS === 1'b0) begin cs_fall = n; last_gap = n - cs_rise; end
    if (prev_cs === 1'b0 && CS === 1'b1) cs_rise = n;
    if (prev_tip === 1'b0 && TIP === 1'b1) tip_rise = n;
    if (prev_tip === 1'b1 && TIP === 1'b0) tip_fall = n;
    prev_cs  = CS;
    prev_tip = TIP;
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic start_frame(input word_t tx, input logic cpha, input int mode, input int div);
    @(negedge sys_clk);
    CPHA      = cpha;
    miso_mode = mode;
    gen_div   = div;
    tx_data   = tx;
    start     = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    for (int k = 0; k < 4000 && done_cnt < target; k++) @(negedge sys_clk);
    check(name, done_cnt >= target, 1);
  endtask

  task automatic wait_samples(input int target, input string name);
    for (int k = 0; k < 4000 && gen_samples < target; k++) @(negedge sys_clk);
    check(name, gen_samples >= target, 1);
  endtask

  int d0, s0, sh0, nrand;

  initial begin
    rst = 1'b1; start = 1'b0; tx_data = '0; CPHA = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("reset_cs",   CS,      1);
    check("reset_tip",  TIP,     0);
    check("reset_mosi", mosi,    0);
    check("reset_busy", busy,    0);
    check("reset_rx",   rx_data, 0);
    rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    // CPHA=0 loopback of 0xA5.
    d0 = done_cnt; s0 = gen_samples;
    start_frame(8'hA5, 1'b0, 0, 1);
    wait_done(d0 + 1, "t1_done_seen");
    repeat (3) @(negedge sys_clk);
    check("t1_rx",        rx_data,           8'hA5);
    check("t1_done_once", done_cnt - d0,     1);
    check("t1_samples",   gen_samples - s0,  8);
    check("t1_mosi_seq",  mosi_word,         8'hA5);
    check("t1_mosi_last", mosi,              1);
    check("t1_setup_gap", tip_rise - cs_fall, SC);
    check("t1_hold_gap",  cs_rise - tip_fall, HC);

    // CPHA=1, 0x3C with miso tied high.
    d0 = done_cnt; s0 = gen_samples; sh0 = gen_shifts;
    start_frame(8'h3C, 1'b1, 1, 2);
    wait_done(d0 + 1, "t2_done_seen");
    repeat (2) @(negedge sys_clk);
    check("t2_mosi_seq",  mosi_word,         8'h3C);
    check("t2_rx",        rx_data,           8'hFF);
    check("t2_shifts",    gen_shifts - sh0,  8);
    check("t2_samples",   gen_samples - s0,  8);
    check("t2_mosi_last", mosi,              0);
    check("t2_setup_gap", tip_rise - cs_fall, SC);
    check("t2_hold_gap",  cs_rise - tip_fall, HC);

    // start re-pulsed mid-XFER is ignored.
    d0 = done_cnt; s0 = gen_samples;
    start_frame(8'h5A, 1'b0, 0, 1);
    wait_samples(s0 + 3, "t3_samples_seen");
    tx_data = 8'hFF; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    wait_done(d0 + 1, "t3_done_seen");
    repeat (6) @(negedge sys_clk);
    check("t3_rx",        rx_data,       8'h5A);
    check("t3_done_once", done_cnt - d0, 1);
    check("t3_idle",      busy,          0);

    // Reset after four samples aborts the frame.
    d0 = done_cnt; s0 = gen_samples;
    start_frame(8'h66, 1'b0, 0, 1);
    wait_samples(s0 + 4, "t4_samples_seen");
    @(negedge sys_clk);
    rst = 1'b1;
    @(negedge sys_clk);
    rst = 1'b0;
    check("t4_cs",   CS,      1);
    check("t4_tip",  TIP,     0);
    check("t4_busy", busy,    0);
    check("t4_rx",   rx_data, 0);
    check("t4_done", done,    0);
    repeat (2) @(negedge sys_clk);
    check("t4_no_done", done_cnt - d0, 0);
    start_frame(8'h81, 1'b1, 0, 1);
    wait_done(d0 + 1, "t4_done_seen");
    repeat (2) @(negedge sys_clk);
    check("t4_rx_after", rx_data, 8'h81);

    // start held high: back-to-back frames with a one-cycle CS-high gap.
    d0 = done_cnt;
    @(negedge sys_clk);
    CPHA = 1'b0; miso_mode = 0; gen_div = 0; tx_data = 8'hC3; start = 1'b1;
    wait_done(d0 + 1, "t5_done1");
    wait_done(d0 + 2, "t5_done2");
    check("t5_gap2", last_gap, 1);
    wait_done(d0 + 3, "t5_done3");
    check("t5_gap3", last_gap, 1);
    start = 1'b0;
    repeat (HC + SC + 6) @(negedge sys_clk);
    check("t5_frames", done_cnt - d0, 3);
    check("t5_rx",     rx_data,       8'hC3);

    // Randomized frames with stray strobes and stray starts.
    noise_en = 1'b1;
    for (int f = 0; f < 40; f++) begin
      d0 = done_cnt;
      start_frame(word_t'($urandom), 1'($urandom_range(0, 1)), 2, $urandom_range(0, 3));
      nrand = $urandom_range(0, 12);
      for (int k = 0; k < nrand; k++) begin
        @(negedge sys_clk);
        start   = ($urandom_range(0, 3) == 0);
        tx_data = word_t'($urandom);
      end
      @(negedge sys_clk);
      start = 1'b0;
      wait_done(d0 + 1, "rand_done_seen");
      repeat ($urandom_range(0, 3)) @(negedge sys_clk);
    end
    noise_en = 1'b0;
    repeat (4) @(negedge sys_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
